// File: rtl/input_conditioner.sv
// Input front end for the project_2 ALU: synchronizes switches, debounces the five
// push buttons and holds the most recently accepted button as a sticky one-hot select.
module input_conditioner #(
  parameter int BITS            = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            CPU_RESETN,
  input  logic [BITS-1:0] SW,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] SW_OUT,
  output logic            BTNC_OUT,
  output logic            BTNU_OUT,
  output logic            BTND_OUT,
  output logic            BTNL_OUT,
  output logic            BTNR_OUT,
  output logic            OP_CHANGE
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  logic [SYNC_STAGES-1:0][BITS-1:0] sw_sync;
  logic [SYNC_STAGES-1:0][4:0]      btn_sync;
  logic [4:0]                       btn_raw;
  logic [4:0]                       press;
  logic [4:0]                       sel_q;
  logic [4:0]                       sel_new;
  logic                             op_change_q;

  // Bit order everywhere is {C, U, D, L, R}, which is also the priority order.
  assign btn_raw = {BTNC, BTNU, BTND, BTNL, BTNR};

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sw_sync  <= '0;
      btn_sync <= '0;
      SW_OUT   <= '0;
    end else begin
      sw_sync[0]  <= SW;
      btn_sync[0] <= btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        btn_sync[i] <= btn_sync[i-1];
      end
      SW_OUT <= sw_sync[SYNC_STAGES-1];
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_btn
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_d;
    logic          level;

    assign level    = btn_sync[SYNC_STAGES-1][g];
    assign press[g] = press_d;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // The press pulse is decided combinationally on the final counted cycle so the
    // select register can capture it on that same edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (level) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!level) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!level) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (level) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    sel_new = 5'b00000;
    if (press[4])      sel_new = 5'b10000;
    else if (press[3]) sel_new = 5'b01000;
    else if (press[2]) sel_new = 5'b00100;
    else if (press[1]) sel_new = 5'b00010;
    else if (press[0]) sel_new = 5'b00001;
  end

  // Sticky select: only an accepted press reloads it, and OP_CHANGE flags a real change.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sel_q       <= '0;
      op_change_q <= 1'b0;
    end else if (|press) begin
      sel_q       <= sel_new;
      op_change_q <= (sel_new != sel_q);
    end else begin
      op_change_q <= 1'b0;
    end
  end

  assign {BTNC_OUT, BTNU_OUT, BTND_OUT, BTNL_OUT, BTNR_OUT} = sel_q;
  assign OP_CHANGE = op_change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

  logic        clk = 1'b0;
  logic        CPU_RESETN;
  logic [15:0] SW;
  logic [4:0]  btn;
  logic        BTNC, BTNU, BTND, BTNL, BTNR;
  logic [15:0] SW_OUT;
  logic        BTNC_OUT, BTNU_OUT, BTND_OUT, BTNL_OUT, BTNR_OUT;
  logic        OP_CHANGE;
  logic [4:0]  sel;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] btn;
    logic [4:0] exp_sel;
    logic       exp_chg;
  } press_vec_t;

  press_vec_t  press_tab[10];
  logic [15:0] sw_tab[4];
  logic [4:0]  cur_sel;
  logic [15:0] prev_sw;

  always #5 clk = ~clk;

  assign {BTNC, BTNU, BTND, BTNL, BTNR} = btn;
  assign sel = {BTNC_OUT, BTNU_OUT, BTND_OUT, BTNL_OUT, BTNR_OUT};

  input_conditioner #(
    .BITS(16),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .CPU_RESETN(CPU_RESETN),
    .SW(SW),
    .BTNC(BTNC),
    .BTNU(BTNU),
    .BTND(BTND),
    .BTNL(BTNL),
    .BTNR(BTNR),
    .SW_OUT(SW_OUT),
    .BTNC_OUT(BTNC_OUT),
    .BTNU_OUT(BTNU_OUT),
    .BTND_OUT(BTND_OUT),
    .BTNL_OUT(BTNL_OUT),
    .BTNR_OUT(BTNR_OUT),
    .OP_CHANGE(OP_CHANGE)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic [15:0] s);
    btn = b;
    SW  = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Holds BTNL at a level for n cycles while confirming nothing gets accepted.
  task automatic bounceHold(input logic level, input int n);
    btn = level ? 5'b00010 : 5'b00000;
    for (int k = 0; k < n; k++) begin
      step(1);
      checkOutput("bounce_sel", 32'(sel), 32'(cur_sel));
      checkOutput("bounce_chg", 32'(OP_CHANGE), 32'd0);
    end
  endtask

  initial begin
    sw_tab[0] = 16'h0000;
    sw_tab[1] = 16'hFFFF;
    sw_tab[2] = 16'h1234;
    sw_tab[3] = 16'h8001;

    press_tab[0] = '{5'b01000, 5'b01000, 1'b1};
    press_tab[1] = '{5'b00011, 5'b00010, 1'b1};
    press_tab[2] = '{5'b01000, 5'b01000, 1'b1};
    press_tab[3] = '{5'b01000, 5'b01000, 1'b0};
    press_tab[4] = '{5'b10001, 5'b10000, 1'b1};
    press_tab[5] = '{5'b00100, 5'b00100, 1'b1};
    press_tab[6] = '{5'b00101, 5'b00100, 1'b0};
    press_tab[7] = '{5'b11111, 5'b10000, 1'b1};
    press_tab[8] = '{5'b00001, 5'b00001, 1'b1};
    press_tab[9] = '{5'b01110, 5'b01000, 1'b1};

    CPU_RESETN = 1'b0;
    applyStimulus(5'b01000, 16'hFFFF);
    step(3);
    checkOutput("reset_sw_out", 32'(SW_OUT), 32'h0);
    checkOutput("reset_sel", 32'(sel), 32'h0);
    checkOutput("reset_chg", 32'(OP_CHANGE), 32'h0);

    CPU_RESETN = 1'b1;
    applyStimulus(5'b00000, 16'hA55A);
    step(2);
    checkOutput("sw_early", 32'(SW_OUT), 32'h0);
    step(1);
    checkOutput("sw_a55a", 32'(SW_OUT), 32'hA55A);
    prev_sw = 16'hA55A;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'b00000, sw_tab[i]);
      step(2);
      checkOutput($sformatf("sw_tab%0d_early", i), 32'(SW_OUT), 32'(prev_sw));
      step(1);
      checkOutput($sformatf("sw_tab%0d", i), 32'(SW_OUT), 32'(sw_tab[i]));
      prev_sw = sw_tab[i];
    end

    applyStimulus(5'b01000, prev_sw);
    step(6);
    checkOutput("clean_c6_sel", 32'(sel), 32'h0);
    checkOutput("clean_c6_chg", 32'(OP_CHANGE), 32'h0);
    step(1);
    checkOutput("clean_c7_sel", 32'(sel), 32'(5'b01000));
    checkOutput("clean_c7_chg", 32'(OP_CHANGE), 32'h1);
    step(1);
    checkOutput("clean_c8_chg", 32'(OP_CHANGE), 32'h0);
    step(2);
    btn = 5'b00000;
    step(12);
    checkOutput("clean_sticky", 32'(sel), 32'(5'b01000));
    checkOutput("clean_release_chg", 32'(OP_CHANGE), 32'h0);
    cur_sel = 5'b01000;

    bounceHold(1'b1, 2);
    bounceHold(1'b0, 1);
    bounceHold(1'b1, 3);
    bounceHold(1'b0, 10);
    btn = 5'b00010;
    step(6);
    checkOutput("bounce_full_c6", 32'(sel), 32'(5'b01000));
    btn = 5'b00000;
    step(1);
    checkOutput("bounce_full_sel", 32'(sel), 32'(5'b00010));
    checkOutput("bounce_full_chg", 32'(OP_CHANGE), 32'h1);
    step(12);
    cur_sel = 5'b00010;

    for (int i = 0; i < 10; i++) begin
      btn = press_tab[i].btn;
      step(6);
      checkOutput($sformatf("tab%0d_c6_sel", i), 32'(sel), 32'(cur_sel));
      checkOutput($sformatf("tab%0d_c6_chg", i), 32'(OP_CHANGE), 32'h0);
      step(1);
      checkOutput($sformatf("tab%0d_sel", i), 32'(sel), 32'(press_tab[i].exp_sel));
      checkOutput($sformatf("tab%0d_chg", i), 32'(OP_CHANGE), 32'(press_tab[i].exp_chg));
      step(1);
      checkOutput($sformatf("tab%0d_c8_chg", i), 32'(OP_CHANGE), 32'h0);
      step(2);
      btn = 5'b00000;
      step(12);
      checkOutput($sformatf("tab%0d_sticky", i), 32'(sel), 32'(press_tab[i].exp_sel));
      cur_sel = press_tab[i].exp_sel;
    end

    btn = 5'b00100;
    step(4);
    CPU_RESETN = 1'b0;
    #1;
    checkOutput("midrst_sel", 32'(sel), 32'h0);
    checkOutput("midrst_chg", 32'(OP_CHANGE), 32'h0);
    step(1);
    CPU_RESETN = 1'b1;
    step(6);
    checkOutput("midrst_c11_sel", 32'(sel), 32'h0);
    step(1);
    checkOutput("midrst_c12_sel", 32'(sel), 32'(5'b00100));
    checkOutput("midrst_c12_chg", 32'(OP_CHANGE), 32'h1);
    btn = 5'b00000;
    step(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
